// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared mode encoding and game state type for the snake game
package snake_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PLAY = 2'b01;
  localparam logic [1:0] MODE_OVER = 2'b10;
  localparam logic [1:0] MODE_WIN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE,
    ST_RESPAWN,
    ST_OVER,
    ST_WIN
  } game_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser and debouncer with a one-cycle press event
module btn_debounce #(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_evt
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      cnt     <= '0;
      btn_evt <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      btn_evt <= 1'b0;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Only a 0->1 toggle of the debounced level is an event
        deb     <= ~deb;
        cnt     <= '0;
        btn_evt <= ~deb;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_mode_fsm.sv
// rtl/game_mode_fsm.sv - snake game mode controller: buttons, lives, level, win/lose
module game_mode_fsm
  import snake_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 13,
  parameter int LIVES       = 3,
  parameter int LEVEL_STEP  = 4,
  parameter int MAX_LEVEL   = 3,
  parameter int DEB_CYC     = 1000000,
  parameter int RESPAWN_CYC = 50000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           btn_start,
  input  logic                           btn_pause,
  input  logic                           hit,
  input  logic [SCORE_W-1:0]             score,
  output logic [1:0]                     mode,
  output logic                           paused,
  output logic [$clog2(LIVES+1)-1:0]     lives,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level,
  output logic                           game_reset,
  output logic                           respawn
);

  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int LVL_W   = $clog2(MAX_LEVEL + 1);
  localparam int RESP_W  = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
  localparam logic [RESP_W-1:0] RESP_LAST = RESP_W'(RESPAWN_CYC - 1);

  logic              start_evt;
  logic              pause_evt;
  logic [SCORE_W-1:0] score_q;
  logic [LVL_W-1:0]  level_tgt;
  logic              win_hit;
  logic [RESP_W-1:0] resp_cnt;
  game_state_t       state;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_start),
    .btn_evt (start_evt)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_pause),
    .btn_evt (pause_evt)
  );

  generate
    if ((LEVEL_STEP & (LEVEL_STEP - 1)) == 0) begin : g_shift
      assign score_q = score >> $clog2(LEVEL_STEP);
    end else begin : g_div
      assign score_q = score / SCORE_W'(LEVEL_STEP);
    end
  endgenerate

  assign level_tgt = (32'(score_q) > MAX_LEVEL) ? LVL_W'(MAX_LEVEL) : LVL_W'(score_q);
  assign win_hit   = (32'(score) >= WIN_SCORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode       <= MODE_IDLE;
      paused     <= 1'b0;
      lives      <= LIVES_W'(LIVES);
      level      <= '0;
      game_reset <= 1'b0;
      respawn    <= 1'b0;
      resp_cnt   <= '0;
    end else begin
      game_reset <= 1'b0;
      respawn    <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER, ST_WIN: begin
          if (start_evt) begin
            state      <= ST_PLAY;
            mode       <= MODE_PLAY;
            game_reset <= 1'b1;
            lives      <= LIVES_W'(LIVES);
            level      <= '0;
          end
        end
        ST_PLAY: begin
          // Level only ratchets upward within a game
          if (level_tgt > level) level <= level_tgt;
          if (win_hit) begin
            state <= ST_WIN;
            mode  <= MODE_WIN;
          end else if (hit) begin
            lives <= lives - LIVES_W'(1);
            if (lives == LIVES_W'(1)) begin
              state <= ST_OVER;
              mode  <= MODE_OVER;
            end else begin
              state    <= ST_RESPAWN;
              resp_cnt <= '0;
            end
          end else if (pause_evt) begin
            state  <= ST_PAUSE;
            paused <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (pause_evt || start_evt) begin
            state  <= ST_PLAY;
            paused <= 1'b0;
          end
        end
        ST_RESPAWN: begin
          if (resp_cnt == RESP_LAST) begin
            state    <= ST_PLAY;
            respawn  <= 1'b1;
            resp_cnt <= '0;
          end else begin
            resp_cnt <= resp_cnt + RESP_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          mode   <= MODE_IDLE;
          paused <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_mode_fsm.sv
// tb/tb_game_mode_fsm.sv - self-checking bench for game_mode_fsm
module tb_game_mode_fsm;

  localparam int DEB  = 4;
  localparam int RESP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start;
  logic       btn_pause;
  logic       hit;
  logic [3:0] score;
  logic [1:0] mode;
  logic       paused;
  logic [1:0] lives;
  logic [1:0] level;
  logic       game_reset;
  logic       respawn;

  int n_cmp  = 0;
  int n_fail = 0;
  int gr_seen;
  int resp_seen;
  int cyc = 0;

  always #5 clk = ~clk;

  game_mode_fsm #(
    .SCORE_W(4), .WIN_SCORE(13), .LIVES(3), .LEVEL_STEP(4),
    .MAX_LEVEL(3), .DEB_CYC(DEB), .RESPAWN_CYC(RESP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .hit(hit), .score(score), .mode(mode), .paused(paused), .lives(lives),
    .level(level), .game_reset(game_reset), .respawn(respawn)
  );

  // Reference model: game rules stated directly, buttons as "run of disagreeing samples"
  typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_RESP, M_OVER, M_WIN} mst_t;
  mst_t m_st;
  int m_lives, m_level, m_gr, m_resp, m_rem;
  int b_d1[2], b_d2[2], b_deb[2], b_run[2], b_evt[2];

  function automatic int mode_of(input mst_t s);
    case (s)
      M_IDLE: return 0;
      M_OVER: return 2;
      M_WIN:  return 3;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_lives = 3; m_level = 0; m_gr = 0; m_resp = 0; m_rem = 0;
    for (int b = 0; b < 2; b++) begin
      b_d1[b] = 0; b_d2[b] = 0; b_deb[b] = 0; b_run[b] = 0; b_evt[b] = 0;
    end
  endtask

  task automatic model_step();
    int raw[2];
    int sevt, pevt, q, s;
    raw[0] = int'(btn_start);
    raw[1] = int'(btn_pause);
    sevt = b_evt[0];
    pevt = b_evt[1];
    m_gr = 0;
    m_resp = 0;
    case (m_st)
      M_IDLE, M_OVER, M_WIN:
        if (sevt != 0) begin
          m_st = M_PLAY; m_lives = 3; m_level = 0; m_gr = 1;
        end
      M_PLAY: begin
        q = int'(score) / 4;
        if (q > 3) q = 3;
        if (q > m_level) m_level = q;
        if (int'(score) >= 13) m_st = M_WIN;
        else if (hit) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_st = M_OVER;
          else begin m_st = M_RESP; m_rem = RESP; end
        end else if (pevt != 0) m_st = M_PAUSE;
      end
      M_PAUSE: if (pevt != 0 || sevt != 0) m_st = M_PLAY;
      M_RESP: begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_st = M_PLAY; m_resp = 1; end
      end
      default: m_st = M_IDLE;
    endcase
    for (int b = 0; b < 2; b++) begin
      s = b_d2[b];
      b_d2[b] = b_d1[b];
      b_d1[b] = raw[b];
      b_evt[b] = 0;
      if (s != b_deb[b]) begin
        b_run[b]++;
        if (b_run[b] == DEB) begin
          b_deb[b] = 1 - b_deb[b];
          b_run[b] = 0;
          b_evt[b] = b_deb[b];
        end
      end else b_run[b] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    cyc++;
    if (game_reset) gr_seen++;
    if (respawn) resp_seen++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    n_cmp++;
    if (mode !== 2'(mode_of(m_st)) || paused !== (m_st == M_PAUSE) ||
        lives !== 2'(m_lives) || level !== 2'(m_level) ||
        game_reset !== 1'(m_gr) || respawn !== 1'(m_resp)) begin
      n_fail++;
      $display("FAIL model cyc %0d: got mode=%0d paused=%0d lives=%0d level=%0d gr=%0d resp=%0d, expected mode=%0d paused=%0d lives=%0d level=%0d gr=%0d resp=%0d",
               cyc, mode, paused, lives, level, game_reset, respawn,
               mode_of(m_st), (m_st == M_PAUSE), m_lives, m_level, m_gr, m_resp);
    end
  endtask

  task automatic press(input int which);
    if (which == 0) btn_start = 1'b1; else btn_pause = 1'b1;
    repeat (10) tick();
    btn_start = 1'b0;
    btn_pause = 1'b0;
    repeat (8) tick();
  endtask

  typedef struct {
    logic hit;
    int   score;
    int   mode;
    int   lives;
    int   level;
    bit   chk_lvl;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int hs, hp;
    vecs[0] = '{1'b0, 0,  1, 3, 0, 1'b1};
    vecs[1] = '{1'b0, 5,  1, 3, 1, 1'b1};
    vecs[2] = '{1'b0, 9,  1, 3, 2, 1'b1};
    vecs[3] = '{1'b0, 6,  1, 3, 2, 1'b1};
    vecs[4] = '{1'b1, 14, 3, 3, 0, 1'b0};

    rst_n = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; hit = 1'b0; score = '0;
    gr_seen = 0; resp_seen = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_mode", mode, 0);
    chk("rst_paused", paused, 0);
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    chk("rst_gr", game_reset, 0);
    chk("rst_resp", respawn, 0);
    rst_n = 1'b1;

    // Bounces shorter than the debounce window
    gr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      btn_start = ((i / 2) % 2 == 0);
      tick();
    end
    btn_start = 1'b0;
    repeat (8) tick();
    chk("bounce_mode", mode, 0);
    chk("bounce_gr", gr_seen, 0);

    gr_seen = 0;
    press(0);
    chk("start_gr_count", gr_seen, 1);
    chk("start_mode", mode, 1);
    chk("start_lives", lives, 3);
    chk("start_level", level, 0);

    hit = 1'b1; tick(); hit = 1'b0;
    chk("hit_lives", lives, 2);
    chk("hit_mode", mode, 1);
    resp_seen = 0;
    for (int i = 1; i <= 7; i++) begin
      hit = (i == 3);
      tick();
      hit = 1'b0;
    end
    chk("resp_early", resp_seen, 0);
    chk("resp_mode", mode, 1);
    chk("resp_hit_lives", lives, 2);
    tick();
    chk("resp_pulse", respawn, 1);
    tick();
    chk("resp_single", resp_seen, 1);

    hit = 1'b1; tick(); hit = 1'b0;
    repeat (8) tick();
    hit = 1'b1; tick(); hit = 1'b0;
    chk("over_lives", lives, 0);
    chk("over_mode", mode, 2);

    gr_seen = 0;
    press(0);
    chk("restart_gr", gr_seen, 1);
    chk("restart_mode", mode, 1);
    chk("restart_lives", lives, 3);

    press(1);
    chk("pause_on", paused, 1);
    hit = 1'b1; score = 4'd15; tick(); hit = 1'b0;
    repeat (3) tick();
    chk("pause_lives", lives, 3);
    chk("pause_mode", mode, 1);
    chk("pause_level", level, 0);
    chk("pause_held", paused, 1);
    score = 4'd0;
    press(1);
    chk("pause_off", paused, 0);
    chk("pause_off_mode", mode, 1);

    for (int i = 0; i < 5; i++) begin
      hit = vecs[i].hit;
      score = 4'(vecs[i].score);
      tick();
      hit = 1'b0;
      chk($sformatf("vec%0d_mode", i), mode, vecs[i].mode);
      chk($sformatf("vec%0d_lives", i), lives, vecs[i].lives);
      if (vecs[i].chk_lvl) chk($sformatf("vec%0d_level", i), level, vecs[i].level);
    end

    // Asynchronous reset in the middle of a respawn dwell
    score = 4'd0;
    press(0);
    score = 4'd5; tick();
    hit = 1'b1; tick(); hit = 1'b0;
    repeat (3) tick();
    chk("pre_rst_level", level, 1);
    chk("pre_rst_lives", lives, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_paused", paused, 0);
    chk("arst_lives", lives, 3);
    chk("arst_level", level, 0);
    chk("arst_gr", game_reset, 0);
    chk("arst_resp", respawn, 0);
    model_reset();
    score = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;

    hs = 0; hp = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hs == 0) begin btn_start = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 12); end
      if (hp == 0) begin btn_pause = 1'($urandom_range(0, 1)); hp = $urandom_range(1, 12); end
      hs--; hp--;
      hit = ($urandom_range(0, 5) == 0);
      if (game_reset) score = 4'd0;
      else if ($urandom_range(0, 9) == 0) score = (score == 4'd15) ? score : score + 4'd1;
      else if ($urandom_range(0, 39) == 0) score = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 699) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
